complement_2: RTL and testbench
===============================

COMPLEMENT_2 -- requirements
Module: complement_2

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning operand and result width in bits (legal range 2..64).
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit, reset, synchronous and active-high.
REQ-004 The block SHALL have port a, input, WIDTH bits, operand to be negated.
REQ-005 The block SHALL have port in_valid, input, 1 bit, qualifies a on the current cycle.
REQ-006 The block SHALL have port b, output, WIDTH bits, registered two's complement of a.
REQ-007 The block SHALL have port out_valid, output, 1 bit, marks b as holding a new result.
REQ-008 The block SHALL have port zero, output, 1 bit, set when the registered result is all zeros.
REQ-009 The block SHALL have port ovf, output, 1 bit, set when a was the most-negative value (MSB 1, rest 0); present only per REQ-020.

Function
REQ-010 On each rising clk edge with rst=0 and in_valid=1, the block SHALL register b = (~a + 1) mod 2^WIDTH, i.e. invert all bits then add one, carry out of the MSB discarded.
REQ-011 Latency SHALL be exactly one cycle: a sampled at edge N appears on b with out_valid=1 after edge N.
REQ-012 With in_valid=0, b, zero and ovf SHALL hold their previous values and out_valid SHALL be 0 on the next cycle.
REQ-013 Back-to-back in_valid=1 cycles SHALL give one result per cycle, no stall, no backpressure.
REQ-014 Boundary a=0 SHALL give b=0 and zero=1; a=all ones SHALL give b=1.
REQ-015 Boundary a=most-negative (e.g. 8'h80) SHALL give b=a unchanged and ovf=1; all other inputs give ovf=0.
REQ-016 zero and ovf SHALL be registered in the same cycle as b and always describe the current b.

Reset
REQ-017 While rst=1 at a rising edge, b SHALL become 0, out_valid 0, zero 0, ovf 0, regardless of in_valid.
REQ-018 Reset SHALL take priority over a simultaneous in_valid=1; that input is discarded, not delayed.
REQ-019 The first valid result after rst deasserts SHALL follow REQ-011 with no extra wait cycles.

Configuration
REQ-020 Macro COMPLEMENT_2_OVF_EN SHALL control the ovf port and its detection logic: defined -> ovf present per REQ-015; undefined -> port and logic absent, all other behaviour unchanged.

Structure
REQ-021 A shared package complement_2_pkg SHALL hold the default width constant (8) and the most-negative-value helper constant/function.
REQ-022 One sub-module complement_2_inc SHALL implement the combinational +1 ripple incrementer over the inverted operand, outputting sum and MSB carry; the top holds only registers, flags and control.

Verification
REQ-023 Reset: rst=1 for 2 cycles with in_valid=1, a=8'h55 -> b=0, out_valid=0, zero=0, ovf=0.
REQ-024 Nominal: a=8'b00101100 (8'h2C), in_valid=1 -> next cycle b=8'hD4, out_valid=1, zero=0, ovf=0.
REQ-025 Zero and all ones: a=8'h00 -> b=8'h00, zero=1; then a=8'hFF -> b=8'h01, zero=0.
REQ-026 Most-negative: a=8'h80 -> b=8'h80, ovf=1 (macro defined); a=8'h7F next cycle -> b=8'h81, ovf=0.
REQ-027 Streaming/hold: a=8'h01,8'h02,8'h03 on consecutive cycles -> b=8'hFF,8'hFE,8'hFD each one cycle later; then in_valid=0 -> b holds 8'hFD, out_valid=0.
REQ-028 Reset mid-stream: rst=1 on the same edge as a=8'h10, in_valid=1 -> b=0, out_valid=0; next cycle no result for 8'h10 appears.

Source files
------------

// File: rtl/complement_2_pkg.sv
// Shared constants and helpers for the complement_2 two's-complement negator.
package complement_2_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;
  localparam int unsigned MAX_WIDTH     = 64;

  // Most-negative value for a w-bit operand: MSB set, every other bit clear.
  function automatic logic [MAX_WIDTH-1:0] most_negative(input int unsigned w);
    return MAX_WIDTH'(1) << (w - 1);
  endfunction

endpackage

// File: rtl/complement_2_inc.sv
// Combinational +1 ripple incrementer; carry_o is the carry out of the MSB.
module complement_2_inc
  import complement_2_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] op_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_o
);

  logic carry_v;

  // A walking carry variable keeps the chain inside one process instead of a
  // self-referencing vector, so the simulator sees no combinational loop.
  always_comb begin
    // NOTE: every output gets a value before any branch or loop, so no latch can form.
    sum_o   = '0;
    carry_v = 1'b1;
    for (int i = 0; i < int'(WIDTH); i++) begin
      sum_o[i] = op_i[i] ^ carry_v;
      carry_v  = op_i[i] & carry_v;
    end
    carry_o = carry_v;
  end

endmodule

// File: rtl/complement_2.sv
// Registered two's-complement negator, one cycle latency, one result per cycle.
// Define COMPLEMENT_2_OVF_EN to add the ovf port and most-negative detection.
module complement_2
  import complement_2_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic             in_valid,
  output logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic             zero
`ifdef COMPLEMENT_2_OVF_EN
  ,
  output logic             ovf
`endif
);

  logic [WIDTH-1:0] neg_sum;
  logic             neg_carry;

  logic [WIDTH-1:0] b_q, b_d;
  logic             valid_q, valid_d;
  logic             zero_q, zero_d;

  complement_2_inc #(.WIDTH(WIDTH)) u_inc (
    .op_i    (~a),
    .sum_o   (neg_sum),
    .carry_o (neg_carry)
  );

  // The incrementer carries out of the MSB only when ~a is all ones, i.e. a == 0,
  // which is exactly when the negated result is zero.
  always_comb begin
    b_d     = b_q;
    zero_d  = zero_q;
    valid_d = in_valid;
    if (in_valid) begin
      b_d    = neg_sum;
      zero_d = neg_carry;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      b_q     <= '0;
      valid_q <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      b_q     <= b_d;
      valid_q <= valid_d;
      zero_q  <= zero_d;
    end
  end

  assign b         = b_q;
  assign out_valid = valid_q;
  assign zero      = zero_q;

`ifdef COMPLEMENT_2_OVF_EN
  localparam logic [WIDTH-1:0] MOST_NEG = WIDTH'(most_negative(WIDTH));

  logic ovf_q, ovf_d;

  always_comb begin
    ovf_d = ovf_q;
    if (in_valid) ovf_d = (a == MOST_NEG);
  end

  always_ff @(posedge clk) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_complement_2.sv
// Self-checking bench for complement_2 (WIDTH=8) using an expected-result queue.
module tb_complement_2;

  localparam int W = 8;
`ifdef COMPLEMENT_2_OVF_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  typedef struct {
    logic [W-1:0] b;
    logic         zero;
    logic         ovf;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] a;
  logic         in_valid;
  logic [W-1:0] b;
  logic         out_valid;
  logic         zero;
  logic         ovf_obs;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

`ifdef COMPLEMENT_2_OVF_EN
  logic ovf;
  assign ovf_obs = ovf;
  complement_2 #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .a(a), .in_valid(in_valid),
    .b(b), .out_valid(out_valid), .zero(zero), .ovf(ovf)
  );
`else
  assign ovf_obs = 1'b0;
  complement_2 #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .a(a), .in_valid(in_valid),
    .b(b), .out_valid(out_valid), .zero(zero)
  );
`endif

  // Drive one cycle; a result is expected only for valid input outside reset.
  task automatic step(input logic r, input logic v, input logic [W-1:0] av,
                      input logic [W-1:0] eb);
    exp_t e;
    rst = r; in_valid = v; a = av;
    if (!r && v) begin
      e.b = eb; e.zero = (eb == '0); e.ovf = OVF_ON && (av == 8'h80);
      sb.push_back(e);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    step(1'b1, 1'b1, 8'h55, 8'h00);
    step(1'b1, 1'b1, 8'h55, 8'h00);
    total++;
    if ({b, out_valid, zero, ovf_obs} !== {8'h00, 3'b000} || sb.size() != 0) begin
      bad++;
      $display("FAIL reset_state: b=%h out_valid=%b zero=%b ovf=%b queued=%0d, required 00/0/0/0 and empty",
               b, out_valid, zero, ovf_obs, sb.size());
    end
  endtask

  task automatic test_table(input string nm, input logic [W-1:0] av[], input logic [W-1:0] eb[]);
    exp_t e;
    foreach (av[i]) begin
      step(1'b0, 1'b1, av[i], eb[i]);
      total++;
      if (out_valid !== 1'b1 || sb.size() != 1) begin
        bad++;
        $display("FAIL %s[%0d] valid: out_valid=%b queued=%0d, required 1 and 1", nm, i, out_valid, sb.size());
        sb.delete();
      end else begin
        e = sb.pop_front();
        total++;
        if ({b, zero, ovf_obs} !== {e.b, e.zero, e.ovf}) begin
          bad++;
          $display("FAIL %s[%0d] a=%h: b=%h zero=%b ovf=%b, required b=%h zero=%b ovf=%b",
                   nm, i, av[i], b, zero, ovf_obs, e.b, e.zero, e.ovf);
        end
      end
    end
  endtask

  task automatic test_nominal();
    test_table("nominal", '{8'h2C}, '{8'hD4});
  endtask

  task automatic test_boundaries();
    test_table("zero_ones", '{8'h00, 8'hFF}, '{8'h00, 8'h01});
    test_table("most_neg", '{8'h80, 8'h7F}, '{8'h80, 8'h81});
  endtask

  task automatic test_back_to_back();
    test_table("stream", '{8'h01, 8'h02, 8'h03}, '{8'hFF, 8'hFE, 8'hFD});
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b0, 8'hA5, 8'h00);
      total++;
      if ({b, out_valid, zero, ovf_obs} !== {8'hFD, 3'b000} || sb.size() != 0) begin
        bad++;
        $display("FAIL hold[%0d]: b=%h out_valid=%b zero=%b ovf=%b, required FD/0/0/0", i, b, out_valid, zero, ovf_obs);
      end
    end
  endtask

  task automatic test_reset_midstream();
    test_table("pre_reset", '{8'h05}, '{8'hFB});
    step(1'b1, 1'b1, 8'h10, 8'h00);
    total++;
    if ({b, out_valid, zero, ovf_obs} !== {8'h00, 3'b000}) begin
      bad++;
      $display("FAIL mid_reset: b=%h out_valid=%b zero=%b ovf=%b, required 00/0/0/0", b, out_valid, zero, ovf_obs);
    end
    step(1'b0, 1'b0, 8'h10, 8'h00);
    total++;
    if ({b, out_valid} !== {8'h00, 1'b0}) begin
      bad++;
      $display("FAIL no_delayed_result: b=%h out_valid=%b, required 00/0", b, out_valid);
    end
    // Zero-wait first result after reset is released, including the flag paths.
    step(1'b1, 1'b0, 8'h00, 8'h00);
    test_table("post_reset", '{8'h80, 8'h00}, '{8'h80, 8'h00});
  endtask

  task automatic test_random();
    logic [W-1:0] av[] = new[24];
    logic [W-1:0] eb[] = new[24];
    foreach (av[i]) begin
      av[i] = W'($urandom_range(0, 255));
      eb[i] = W'(0) - av[i];
    end
    test_table("random", av, eb);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = '0;
    test_reset();
    test_nominal();
    test_boundaries();
    test_back_to_back();
    test_reset_midstream();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation still running at %0t, required completion", $time);
    $fatal(1);
  end

endmodule
